// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request/response port and a word-wide synchronous RAM.
// Sub-word stores are done as read-modify-write; illegal accesses answer with an error and never touch RAM.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic        ram_write,
    output logic [31:0] ram_datain,
    input  logic [31:0] ram_dataout
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    state_t      state, next_state;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        we_q, unsigned_q, err_q;
    logic        accept, req_err;
    logic [31:0] merged, load_fmt;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({1'b0, req_addr} >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                we_q       <= req_we;
                unsigned_q <= req_unsigned;
                err_q      <= req_err;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = DONE;
                    else if (req_we && req_size == 2'b10)
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:      next_state = we_q ? MERGE : DONE;
            MERGE:   next_state = DONE;
            WR:      next_state = DONE;
            DONE:    next_state = resp_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    // RAM output stays valid through DONE because the address is held and nothing writes.
    always_comb begin
        byte_val = ram_dataout[{addr_q[1:0], 3'b000} +: 8];
        half_val = ram_dataout[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_fmt = unsigned_q ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_fmt = unsigned_q ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_fmt = ram_dataout;
        endcase

        merged = ram_dataout;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        req_ready   = (state == IDLE);
        resp_valid  = (state == DONE);
        resp_err    = (state == DONE) && err_q;
        resp_rdata  = 32'd0;
        ram_address = {2'b00, addr_q[31:2]};
        ram_write   = 1'b0;
        ram_datain  = 32'd0;
        case (state)
            WR: begin
                ram_write  = !clr;
                ram_datain = wdata_q;
            end
            MERGE: begin
                ram_write  = !clr;
                ram_datain = merged;
            end
            DONE: begin
                if (!we_q && !err_q)
                    resp_rdata = load_fmt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a simple synchronous RAM plus a byte-addressed memory model
// that predicts load results, merged store words, error responses and latency.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic        ram_write;
    logic [31:0] ram_datain;
    logic [31:0] ram_dataout = 32'd0;

    logic [31:0] ram   [0:1023];
    logic [31:0] model [0:1023];
    int checks = 0;
    int passes = 0;

    mem_access_unit #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_address(ram_address),
        .ram_write(ram_write), .ram_datain(ram_datain), .ram_dataout(ram_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write)
            ram[ram_address[9:0]] <= ram_datain;
        ram_dataout <= ram[ram_address[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] modelByte(input logic [31:0] a);
        logic [31:0] w;
        w = model[a[11:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic legalAccess(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b0;
        if (addr % (32'd1 << size) != 0) return 1'b0;
        return addr < 32'd4096;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 0;
        for (int i = 0; i < n; i++)
            v = v | (32'(modelByte(addr + i)) << (8 * i));
        if (!uns && n < 4 && v[8*n-1])
            v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a;
        for (int i = 0; i < (1 << size); i++) begin
            a = addr + i;
            model[a[11:2]][8*a[1:0] +: 8] = data[8*i +: 8];
        end
    endtask

    // One complete access: issue, follow it to DONE, hold the response, release.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic legal, sawWrite;
        logic [31:0] expData, expWord, held;
        int expLat, lat, w;
        legal   = legalAccess(size, addr);
        expLat  = !legal ? 1 : (!we || size == 2'b10) ? 2 : 3;
        expData = (legal && !we) ? modelLoad(size, uns, addr) : 32'd0;
        if (legal && we) modelStore(size, addr, wdata);
        expWord = model[addr[11:2]];

        w = 0;
        while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
        check("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;

        lat = 1;
        sawWrite = 1'b0;
        while (!resp_valid && lat < 8) begin
            if (legal) check("ram_address", ram_address, {2'b00, addr[31:2]});
            if (ram_write) begin
                sawWrite = 1'b1;
                check("ram_datain", ram_datain, expWord);
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(expLat));
        check("wrote", {31'd0, sawWrite}, {31'd0, legal && we});
        check("resp_err", {31'd0, resp_err}, {31'd0, !legal});
        check("resp_rdata", resp_rdata, expData);

        held = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, held);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("released_valid", {31'd0, resp_valid}, 32'd0);
        check("released_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_ram_write"}, {31'd0, ram_write}, 32'd0);
        check({tag, "_ram_address"}, ram_address, 32'd0);
        check({tag, "_ram_datain"}, ram_datain, 32'd0);
    endtask

    initial begin
        logic [1:0]  rsize;
        logic [31:0] raddr;
        for (int i = 0; i < 1024; i++) begin ram[i] = 32'd0; model[i] = 32'd0; end
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        checkOutput("reset");

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 0);
        @(posedge clk); #1;
        check("merged_word", ram[4], 32'h1122AA44);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001AA44, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);

        for (int k = 0; k < 40; k++) begin
            rsize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            raddr = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 15) : 32'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)), raddr,
                          $urandom, $urandom_range(0, 2));
        end

        // Reset in the MERGE cycle must kill the write and the pending response.
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h11; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("merge_write_on", {31'd0, ram_write}, 32'd1);
        clr = 1'b1;
        #1;
        check("merge_write_gated", {31'd0, ram_write}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        checkOutput("midreset");
        @(posedge clk); #1;
        check("midreset_ram", ram[4], model[4]);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
